// File: rtl/osc_meter_pkg.sv
// osc_meter_pkg
// Shared definitions for the oscillator frequency meter:
//   - meter_state_e : measurement FSM states (IDLE, GATE, LATCH)
//   - GATE_SEL_W    : width of the gate window select
//   - gate_len()    : gate window length in clk cycles for a given select
package osc_meter_pkg;

    localparam int GATE_SEL_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GATE  = 2'd1,
        LATCH = 2'd2
    } meter_state_e;

    // Window length N = 2^(min_log2 + sel) clk cycles.
    function automatic logic [31:0] gate_len(input logic [GATE_SEL_W-1:0] sel,
                                             input int min_log2);
        return 32'd1 << (min_log2 + int'(sel));
    endfunction

endpackage

// File: rtl/osc_sync_edge.sv
// osc_sync_edge
// Brings an asynchronous oscillator tap into the clk domain through a
// two-flop synchronizer and emits a one-cycle pulse on each rising edge.
// Shared by every divided tap that needs counting.
// Ports:
//   clk     in  system clock
//   rst_n   in  asynchronous active-low reset, clears all flops to 0
//   async_i in  asynchronous tap
//   rise_o  out one-cycle pulse, high in the cycle a rising edge is seen
module osc_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic rise_o
);

    logic meta_q;   // first synchronizer stage, may go metastable
    logic sync_q;   // second synchronizer stage, safe to use
    logic sync_qq;  // previous value of sync_q for edge detection

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            sync_qq <= 1'b0;
        end else begin
            meta_q  <= async_i;
            sync_q  <= meta_q;
            sync_qq <= sync_q;
        end
    end

    assign rise_o = sync_q & ~sync_qq;

endmodule

// File: rtl/osc_freq_meter.sv
// osc_freq_meter
// Counts rising edges of an asynchronous oscillator tap over a gate window
// of N = 2^(GATE_MIN_LOG2 + gate_sel) clk cycles and publishes the count.
// Ports:
//   clk        in  system clock
//   rst_n      in  asynchronous active-low reset
//   osc_in     in  oscillator tap (async, <= clk/2 for exact counts)
//   gate_sel   in  window select, captured when a measurement starts
//   start      in  level-sampled request, honoured only in IDLE
//   continuous in  re-arm automatically after each publish
//   busy       out measurement window open or latching
//   done       out one-cycle pulse when result/overflow are published
//   result     out last published count, held until the next publish
//   overflow   out published count saturated
//   state_dbg  out current FSM state, for observation only
//
// Request/complete protocol: start is a level, sampled on every clk edge while
// the FSM is IDLE; there is no ready/ack and a start seen while busy is
// dropped, not queued. done is a registered single-cycle strobe; result and
// overflow are valid from the done cycle and only change on done or reset.
module osc_freq_meter
    import osc_meter_pkg::*;
#(
    parameter int GATE_MIN_LOG2 = 10,
    parameter int CNT_W         = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  osc_in,
    input  logic [GATE_SEL_W-1:0] gate_sel,
    input  logic                  start,
    input  logic                  continuous,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W-1:0]      result,
    output logic                  overflow,
    output meter_state_e          state_dbg
);

    // Wide enough for the longest window (select 7) with margin, so the
    // gate counter never wraps.
    localparam int GATE_W = GATE_MIN_LOG2 + 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    meter_state_e          state_q, state_d;
    logic [GATE_SEL_W-1:0] gate_reg_q, gate_reg_d;
    logic [GATE_W-1:0]     gate_cnt_q, gate_cnt_d;
    logic [CNT_W-1:0]      edge_cnt_q, edge_cnt_d;
    logic [CNT_W-1:0]      result_q, result_d;
    logic                  sat_q, sat_d;
    logic                  overflow_q, overflow_d;
    logic                  done_q, done_d;
    logic                  osc_rise;
    logic                  gate_last;
    logic [31:0]           gate_len_w;

    osc_sync_edge u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (osc_in),
        .rise_o  (osc_rise)
    );

    // gate_cnt starts at 0 in the first GATE cycle, so N-1 marks the last one.
    assign gate_len_w = gate_len(gate_reg_q, GATE_MIN_LOG2);
    assign gate_last  = (gate_cnt_q == GATE_W'(gate_len_w - 32'd1));

    always_comb begin
        state_d    = state_q;
        gate_reg_d = gate_reg_q;
        gate_cnt_d = gate_cnt_q;
        edge_cnt_d = edge_cnt_q;
        sat_d      = sat_q;
        result_d   = result_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = GATE;
                    gate_reg_d = gate_sel;
                    gate_cnt_d = '0;
                    edge_cnt_d = '0;
                    sat_d      = 1'b0;
                end
            end
            GATE: begin
                gate_cnt_d = gate_cnt_q + GATE_W'(1);
                if (osc_rise) begin
                    if (edge_cnt_q == CNT_MAX) begin
                        sat_d = 1'b1;
                    end else begin
                        edge_cnt_d = edge_cnt_q + CNT_W'(1);
                    end
                end
                if (gate_last) begin
                    state_d = LATCH;
                end
            end
            LATCH: begin
                // The edge pulse in this cycle is deliberately not counted.
                result_d   = edge_cnt_q;
                overflow_d = sat_q;
                done_d     = 1'b1;
                if (continuous) begin
                    state_d    = GATE;
                    gate_reg_d = gate_sel;
                    gate_cnt_d = '0;
                    edge_cnt_d = '0;
                    sat_d      = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gate_reg_q <= '0;
            gate_cnt_q <= '0;
            edge_cnt_q <= '0;
            sat_q      <= 1'b0;
            result_q   <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            gate_reg_q <= gate_reg_d;
            gate_cnt_q <= gate_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            sat_q      <= sat_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign result    = result_q;
    assign overflow  = overflow_q;
    assign state_dbg = state_q;

endmodule

// File: doc/osc_freq_meter.md
# osc_freq_meter

Digital frequency meter that sits at the receiving end of the ring-oscillator output chain. It takes an asynchronous oscillator tap (raw or divided) and counts its rising edges over a programmable gate window of system clocks. It latches the count as a 16-bit result, which lets on-chip logic or the test harness read the oscillator frequency as a digital word.

## Interface
Parameters:
- GATE_MIN_LOG2, default 10: log2 of the shortest gate window, in clk cycles.
- CNT_W, default 16: width of the result and of the edge counter.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- osc_in  input  1  oscillator tap, asynchronous to clk; must be ≤ clk/2 for exact counts.
- gate_sel  input  3  gate window select: N = 2^(GATE_MIN_LOG2 + gate_sel) cycles.
- start  input  1  level-sampled request to begin a measurement.
- continuous  input  1  when 1, re-arm automatically after each measurement.
- busy  output  1  high while a gate window is open or latching.
- done  output  1  one-cycle pulse when a new result is published.
- result  output  CNT_W  last published edge count, held until the next publish.
- overflow  output  1  set with a publish whose count saturated.

## Operation
- Input path: osc_in → 2-FF synchronizer → rising-edge detector (sync_q & ~sync_qq). An edge is counted in the cycle the detector output is 1.
- FSM states: IDLE, GATE, LATCH.
  - IDLE: if start=1 at a clk edge, capture gate_sel into gate_reg, clear edge_cnt and gate_cnt, go to GATE. Otherwise stay.
  - GATE: gate_cnt increments every cycle. edge_cnt increments on each detected edge, saturating at 2^CNT_W−1; sat_flag is set if an increment is attempted at max. After exactly N cycles in GATE, go to LATCH.
  - LATCH: copy edge_cnt→result and sat_flag→overflow, and pulse done. If continuous=1, clear the counters, re-capture gate_sel and go to GATE. Otherwise go to IDLE.
- busy = (state != IDLE).
- The edge detected in the last GATE cycle is counted. The detector output during the LATCH cycle is discarded, and is also discarded in continuous mode.
- gate_sel changes mid-window are ignored until the next capture.
- start while busy is ignored, with no queueing. start held high in IDLE with continuous=0 starts a new measurement on each return to IDLE.
- continuous dropped mid-window: the current window completes, then the FSM returns to IDLE.
- Reset (any time, including mid-GATE) values: state=IDLE, result=0, overflow=0, done=0, busy=0, counters=0, synchronizer flops=0.

## Timing
- Synchronizer plus detector latency: an osc_in rising edge is counted 2–3 cycles later, depending on phase.
- start sampled high at edge t: GATE occupies cycles t+1 … t+N, LATCH is cycle t+N+1, and done/result/overflow are visible from the edge ending LATCH, i.e. during cycle t+N+2.
- Single measurement: busy is high for N+1 cycles.
- Continuous mode: done pulses every N+1 cycles.
- done is registered, exactly one cycle wide. result and overflow change only on a done cycle or on reset.
- Gate counter width is GATE_MIN_LOG2+8 bits, so wrap-around never occurs.

## Structure
- Package osc_meter_pkg holds:
  - the state enum (IDLE, GATE, LATCH);
  - GATE_SEL_W=3;
  - a function gate_len(sel) returning the window length.
- Sub-module osc_sync_edge: 2-FF synchronizer plus rising-edge pulse. Reset clears it to 0. It is reused for the other divided taps.
- The top contains the FSM, gate counter, saturating edge counter and output registers.

## Test plan
- Exact count: osc_in=clk/4 square, gate_sel=0, start pulse → after 1026 cycles done=1, result=256, overflow=0, busy low for the following cycle.
- Saturation: osc_in=clk/2, gate_sel=7 (131072 cycles) → result=0xFFFF, overflow=1. Repeat with gate_sel=6 → result=32768, overflow=0.
- Continuous: osc_in=clk/8, gate_sel=1, continuous=1 → done pulses spaced exactly 2049 cycles apart, each with result=256. Drop continuous mid-window → one more done, then busy=0.
- Start while busy: pulse start at cycle 500 of a gate_sel=0 window with osc=clk/4 → single done at the original time, result=256, no second measurement.
- Reset mid-GATE: assert rst_n=0 at cycle 300 of a window → busy, done, result and overflow are 0 immediately (asynchronous). After release the FSM is in IDLE until start.
- gate_sel change mid-window: capture gate_sel=0, switch to 3 at cycle 100, osc=clk/4 → done after 1026 cycles with result=256.
